// File: rtl/daq3_spi_pkg.sv
// Shared constants and types for the DAQ3 three-wire SPI bus.
// The initiator, the responder and the benches all use these definitions,
// so the frame layout is defined in one place.
//   INSTR_BITS : instruction length (R/W bit + address)
//   DATA_BITS  : bits per data byte
//   ADDR_BITS  : register address width
//   RW_BIT     : instruction bit carrying R/W (1 = read)
package daq3_spi_pkg;

    localparam int INSTR_BITS = 16;
    localparam int DATA_BITS  = 8;
    localparam int ADDR_BITS  = 15;
    localparam int RW_BIT     = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } spi_state_e;

    // Stream address step; wraps naturally modulo 2^ADDR_BITS.
    function automatic logic [ADDR_BITS-1:0] addr_step(input logic [ADDR_BITS-1:0] addr,
                                                       input logic                 dec);
        return dec ? (addr - ADDR_BITS'(1)) : (addr + ADDR_BITS'(1));
    endfunction

endpackage

// File: rtl/daq3_spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, followed by a one-cycle
// delay register for edge detection.
//   clk    : fabric clock
//   resetn : asynchronous active-low reset
//   d      : asynchronous input pin
//   q      : synchronized level
//   rise   : q = 1 and delayed q = 0 (one cycle)
//   fall   : q = 0 and delayed q = 1 (one cycle)
// RESET_VAL sets the level the chain (and the delay register) assume while
// in reset, which decides which edge, if any, is reported right after reset.
module daq3_spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              dly_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_r <= {STAGES{RESET_VAL}};
            dly_r  <= RESET_VAL;
        end else begin
            sync_r <= (sync_r << 1) | STAGES'(d);
            dly_r  <= sync_r[STAGES-1];
        end
    end

    assign q    = sync_r[STAGES-1];
    assign rise = q & ~dly_r;
    assign fall = ~q & dly_r;

endmodule

// File: rtl/daq3_spi_responder.sv
// Three-wire SPI responder (mode 0) for the DAQ3 control bus.
// Decodes a 16-bit instruction (R/W + 15-bit address), then streams data
// bytes to/from a synchronous byte-wide register port. All SPI pins are
// oversampled in the clk domain.
//   clk, resetn           : fabric clock, async active-low reset
//   spi_csn/clk/sdi       : SPI pins in (chip select active low)
//   spi_sdo, spi_sdo_en   : SDIO output data and drive enable
//   reg_wr, reg_rd        : one-cycle write / read strobes
//   reg_addr, reg_wdata   : register address and write data (held)
//   reg_rdata             : read data, valid the cycle after reg_rd
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus idle, bit counter preloaded; waits for a csn fall
// ST_INSTR | shifting the 16 instruction bits
// ST_WDATA | shifting write bytes; each full byte commits a write
// ST_RDATA | serializing read bytes; each 8th rise fetches the next one
module daq3_spi_responder
    import daq3_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit ADDR_DEC    = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 spi_csn,
    input  logic                 spi_clk,
    input  logic                 spi_sdi,
    output logic                 spi_sdo,
    output logic                 spi_sdo_en,
    output logic                 reg_wr,
    output logic                 reg_rd,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [DATA_BITS-1:0] reg_wdata,
    input  logic [DATA_BITS-1:0] reg_rdata
);

    logic csn_q, csn_rise, csn_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic sdi_q, sdi_rise, sdi_fall;
    logic unused_edges;

    // The csn chain resets to "selected" so that a csn already held low
    // across reset release never looks like a fresh fall; a transfer can
    // only start after csn has been seen high and then low again.
    daq3_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_csn),
        .q      (csn_q),
        .rise   (csn_rise),
        .fall   (csn_fall)
    );

    daq3_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_clk),
        .q      (sclk_q),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    daq3_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk    (clk),
        .resetn (resetn),
        .d      (spi_sdi),
        .q      (sdi_q),
        .rise   (sdi_rise),
        .fall   (sdi_fall)
    );

    assign unused_edges = &{1'b0, csn_rise, sclk_q, sdi_rise, sdi_fall};

    spi_state_e state, state_nxt;

    // Down-counter over the bits of the current field; 0 = last bit.
    logic [3:0]                bit_cnt;
    logic [INSTR_BITS-2:0]     sh_in;
    logic [DATA_BITS-1:0]      sh_out;
    logic                      rd_cap;

    logic take_bit, instr_done, wbyte_done, rbyte_done, drive_bit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // csn high is checked before any spi_clk edge so a deassert seen in the
    // same cycle as a rise always wins and nothing commits.
    always_comb begin
        state_nxt  = state;
        take_bit   = 1'b0;
        instr_done = 1'b0;
        wbyte_done = 1'b0;
        rbyte_done = 1'b0;
        drive_bit  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_nxt = ST_INSTR;
                end
            end
            ST_INSTR: begin
                if (csn_q) begin
                    state_nxt = ST_IDLE;
                end else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        instr_done = 1'b1;
                        // sh_in[14] holds the first bit shifted in: R/W.
                        state_nxt  = sh_in[INSTR_BITS-2] ? ST_RDATA : ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (csn_q) begin
                    state_nxt = ST_IDLE;
                end else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        wbyte_done = 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                if (csn_q) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (sclk_rise) begin
                        take_bit = 1'b1;
                        if (bit_cnt == 4'd0) begin
                            rbyte_done = 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        drive_bit = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= 4'(INSTR_BITS - 1);
            sh_in      <= '0;
            sh_out     <= '0;
            rd_cap     <= 1'b0;
            reg_wr     <= 1'b0;
            reg_rd     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            spi_sdo    <= 1'b0;
            spi_sdo_en <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            rd_cap <= reg_rd;

            if (state == ST_IDLE) begin
                bit_cnt <= 4'(INSTR_BITS - 1);
            end else if (take_bit) begin
                bit_cnt <= (bit_cnt == 4'd0) ? 4'(DATA_BITS - 1) : bit_cnt - 4'd1;
            end

            if (take_bit) begin
                sh_in <= {sh_in[INSTR_BITS-3:0], sdi_q};
            end

            // A write keeps its address for the strobe cycle and steps
            // afterwards; a read steps together with the prefetch strobe.
            if (instr_done) begin
                reg_addr <= {sh_in[ADDR_BITS-2:0], sdi_q};
                reg_rd   <= sh_in[INSTR_BITS-2];
            end else if (rbyte_done) begin
                reg_addr <= addr_step(reg_addr, ADDR_DEC);
                reg_rd   <= 1'b1;
            end else if (reg_wr) begin
                reg_addr <= addr_step(reg_addr, ADDR_DEC);
            end

            if (wbyte_done) begin
                reg_wdata <= {sh_in[DATA_BITS-2:0], sdi_q};
                reg_wr    <= 1'b1;
            end

            if (rd_cap) begin
                sh_out <= reg_rdata;
            end else if (drive_bit) begin
                sh_out <= {sh_out[DATA_BITS-2:0], 1'b0};
            end

            if (state_nxt == ST_IDLE) begin
                spi_sdo    <= 1'b0;
                spi_sdo_en <= 1'b0;
            end else if (drive_bit) begin
                spi_sdo    <= sh_out[DATA_BITS-1];
                spi_sdo_en <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_daq3_spi_responder.sv
module tb_daq3_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csn0, csn1, sclk, sdi;
    logic        sdo0, en0, wr0, rd0;
    logic        sdo1, en1, wr1, rd1;
    logic [14:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    // Expected strobes: {wr, addr[14:0], data[7:0]}
    logic [23:0] exp_q0[$];
    logic [23:0] exp_q1[$];

    always #5 clk = ~clk;

    daq3_spi_responder #(.SYNC_STAGES(2), .ADDR_DEC(1'b0)) u_inc (
        .clk        (clk),
        .resetn     (resetn),
        .spi_csn    (csn0),
        .spi_clk    (sclk),
        .spi_sdi    (sdi),
        .spi_sdo    (sdo0),
        .spi_sdo_en (en0),
        .reg_wr     (wr0),
        .reg_rd     (rd0),
        .reg_addr   (addr0),
        .reg_wdata  (wdata0),
        .reg_rdata  (rdata0)
    );

    daq3_spi_responder #(.SYNC_STAGES(2), .ADDR_DEC(1'b1)) u_dec (
        .clk        (clk),
        .resetn     (resetn),
        .spi_csn    (csn1),
        .spi_clk    (sclk),
        .spi_sdi    (sdi),
        .spi_sdo    (sdo1),
        .spi_sdo_en (en1),
        .reg_wr     (wr1),
        .reg_rd     (rd1),
        .reg_addr   (addr1),
        .reg_wdata  (wdata1),
        .reg_rdata  (rdata1)
    );

    function automatic logic [7:0] mem(input logic [14:0] a);
        case (a)
            15'h0034: return 8'h5A;
            15'h0000: return 8'hC3;
            15'h7FFF: return 8'h3C;
            default:  return a[7:0] ^ 8'h96;
        endcase
    endfunction

    // Register-file model: data valid only in the cycle after reg_rd.
    always @(posedge clk) begin
        rdata0 <= rd0 ? mem(addr0) : 8'h00;
        rdata1 <= rd1 ? mem(addr1) : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int sel, input logic wr, input logic [14:0] a,
                                 input logic [7:0] d);
        if (sel == 0) exp_q0.push_back({wr, a, d});
        else          exp_q1.push_back({wr, a, d});
    endfunction

    task automatic mon(input int sel, input logic wr, input logic rd,
                       input logic [14:0] a, input logic [7:0] d);
        logic [23:0] e;
        int          sz;
        sz = (sel == 0) ? exp_q0.size() : exp_q1.size();
        check("strobe_excl", 32'(wr & rd), 32'd0);
        check("strobe_expected", 32'(sz != 0), 32'd1);
        if (sz == 0) return;
        e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check("strobe_kind", 32'(wr), 32'(e[23]));
        check("strobe_addr", 32'(a), 32'(e[22:8]));
        if (e[23]) check("strobe_wdata", 32'(d), 32'(e[7:0]));
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (wr0 || rd0) mon(0, wr0, rd0, addr0, wdata0);
            if (wr1 || rd1) mon(1, wr1, rd1, addr1, wdata1);
        end
    end

    task automatic set_csn(input int sel, input logic v);
        if (sel == 0) csn0 = v;
        else          csn1 = v;
    endtask

    // Mode 0 bits, MSB of 'bits' first. The initiator samples SDO just
    // before each rise; enable must be high only on read-data bits.
    task automatic send_bits(input int sel, input logic [47:0] bits, input int n,
                             output logic [47:0] rx);
        logic en_now;
        rx = '0;
        for (int i = 0; i < n; i++) begin
            sdi = bits[47-i];
            repeat (HALF) @(negedge clk);
            rx[47-i] = (sel == 0) ? sdo0 : sdo1;
            en_now   = (sel == 0) ? en0 : en1;
            check("sdo_en_bit", 32'(en_now), 32'(bits[47] && (i >= 16)));
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input int sel, input logic [15:0] instr, input logic [31:0] wd,
                        input int nbytes, output logic [31:0] rd);
        logic [47:0] rx;
        set_csn(sel, 1'b0);
        repeat (HALF) @(negedge clk);
        send_bits(sel, {instr, wd}, 16 + 8 * nbytes, rx);
        repeat (HALF) @(negedge clk);
        set_csn(sel, 1'b1);
        repeat (10) @(negedge clk);
        check("sdo_en_after", 32'((sel == 0) ? en0 : en1), 32'd0);
        rd = rx[31:0];
    endtask

    initial begin
        logic [31:0] rd;
        logic [47:0] rx;

        resetn = 1'b0;
        csn0 = 1'b1; csn1 = 1'b1; sclk = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sdo", 32'(sdo0), 32'd0);
        check("rst_sdo_en", 32'(en0), 32'd0);
        check("rst_wr", 32'(wr0), 32'd0);
        check("rst_rd", 32'(rd0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_wdata", 32'(wdata0), 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Single write
        push(0, 1'b1, 15'h0012, 8'hA5);
        xfer(0, 16'h0012, 32'hA500_0000, 1, rd);
        check("wr1_drained", 32'(exp_q0.size()), 32'd0);
        check("wr1_wdata", 32'(wdata0), 32'hA5);

        // Single read (the 8th data rise also prefetches the next address)
        push(0, 1'b0, 15'h0034, 8'h00);
        push(0, 1'b0, 15'h0035, 8'h00);
        xfer(0, 16'h8034, 32'h0, 1, rd);
        check("rd1_byte", 32'(rd[31:24]), 32'h5A);
        check("rd1_drained", 32'(exp_q0.size()), 32'd0);

        // Streaming write with address wrap
        push(0, 1'b1, 15'h7FFF, 8'h11);
        push(0, 1'b1, 15'h0000, 8'h22);
        push(0, 1'b1, 15'h0001, 8'h33);
        xfer(0, 16'h7FFF, 32'h1122_3300, 3, rd);
        check("wrs_drained", 32'(exp_q0.size()), 32'd0);
        check("wrs_wdata", 32'(wdata0), 32'h33);

        // Streaming read, decrementing instance
        push(1, 1'b0, 15'h0000, 8'h00);
        push(1, 1'b0, 15'h7FFF, 8'h00);
        push(1, 1'b0, 15'h7FFE, 8'h00);
        xfer(1, 16'h8000, 32'h0, 2, rd);
        check("rds_byte0", 32'(rd[31:24]), 32'hC3);
        check("rds_byte1", 32'(rd[23:16]), 32'h3C);
        check("rds_drained", 32'(exp_q1.size()), 32'd0);

        // Aborted write after 20 rises
        csn0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(0, {16'h0055, 8'hF0, 24'h0}, 20, rx);
        repeat (HALF) @(negedge clk);
        csn0 = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_drained", 32'(exp_q0.size()), 32'd0);
        check("abort_addr", 32'(addr0), 32'h0055);
        check("abort_wdata", 32'(wdata0), 32'h33);
        push(0, 1'b1, 15'h0056, 8'h6C);
        xfer(0, 16'h0056, 32'h6C00_0000, 1, rd);
        check("post_abort_drained", 32'(exp_q0.size()), 32'd0);
        check("post_abort_wdata", 32'(wdata0), 32'h6C);

        // csn deassert coincident with the 24th rise
        csn0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(0, {16'h0077, 8'h3E, 24'h0}, 23, rx);
        sdi = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        csn0 = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        check("coinc_drained", 32'(exp_q0.size()), 32'd0);
        check("coinc_wdata", 32'(wdata0), 32'h6C);
        check("coinc_addr", 32'(addr0), 32'h0077);

        // Reset in the middle of a read data phase
        push(0, 1'b0, 15'h0034, 8'h00);
        csn0 = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(0, {16'h8034, 32'h0}, 19, rx);
        repeat (3) @(negedge clk);
        check("midrd_en", 32'(en0), 32'd1);
        resetn = 1'b0;
        #1;
        check("mrst_sdo", 32'(sdo0), 32'd0);
        check("mrst_sdo_en", 32'(en0), 32'd0);
        check("mrst_wr", 32'(wr0), 32'd0);
        check("mrst_rd", 32'(rd0), 32'd0);
        check("mrst_addr", 32'(addr0), 32'd0);
        check("mrst_wdata", 32'(wdata0), 32'd0);
        check("mrst_drained", 32'(exp_q0.size()), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        // csn still low: no fresh fall, so these clocks must do nothing
        send_bits(0, {24'h001122, 24'h0}, 24, rx);
        repeat (HALF) @(negedge clk);
        csn0 = 1'b1;
        repeat (10) @(negedge clk);
        check("stale_drained", 32'(exp_q0.size()), 32'd0);
        check("stale_wdata", 32'(wdata0), 32'd0);
        push(0, 1'b1, 15'h0100, 8'h5C);
        xfer(0, 16'h0100, 32'h5C00_0000, 1, rd);
        check("post_rst_drained", 32'(exp_q0.size()), 32'd0);
        check("post_rst_wdata", 32'(wdata0), 32'h5C);

        check("final_q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
